// File: rtl/adder17_arbiter.sv
// Round-robin arbiter that time-shares one external 17+17->18-bit unsigned adder
// among NUM_REQ requesters, one transaction in flight, results tagged by requester ID.
module adder17_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [17*NUM_REQ-1:0]   req_a,
    input  logic [17*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [0:16]             add_a,
    output logic [0:16]             add_b,
    input  logic [0:17]             add_sum,
    output logic                    res_valid,
    output logic [ID_W-1:0]         res_id,
    output logic [0:17]             res_data,
    input  logic                    res_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_pend_id;
    logic [ID_W-1:0]    w_grant_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_found;
    logic               w_allow;
    logic               w_accept;
    logic [0:16]        r_add_a;
    logic [0:16]        r_add_b;
    logic [0:17]        r_res_data;
    logic [ID_W-1:0]    r_res_id;

    // Lowest valid index at or above the pointer wins; otherwise lowest below it.
    // The second loop overrides the first, so the wrap-around region only wins when
    // nothing at or above the pointer is requesting.
    always_comb begin
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) < r_ptr)) begin
                w_grant_idx = ID_W'(i);
                w_found     = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= r_ptr)) begin
                w_grant_idx = ID_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    assign w_allow   = !rst && ((r_state == S_IDLE) || ((r_state == S_RESP) && res_ready));
    assign w_accept  = w_allow && w_found;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_ptr_nxt = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_ADD;
            end
            S_ADD: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (res_ready) w_state_nxt = w_accept ? S_ADD : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_ptr <= w_ptr_nxt;
        end
    end

    // Operands stay put outside ADD; the sum is captured exactly once per transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_pend_id  <= '0;
            r_res_data <= '0;
            r_res_id   <= '0;
        end else begin
            if (w_accept) begin
                r_add_a   <= req_a[17*w_grant_idx +: 17];
                r_add_b   <= req_b[17*w_grant_idx +: 17];
                r_pend_id <= w_grant_idx;
            end
            if (r_state == S_ADD) begin
                r_res_data <= add_sum;
                r_res_id   <= r_pend_id;
            end
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign res_valid = (r_state == S_RESP);
    assign res_id    = r_res_id;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_adder17_arbiter.sv
// Bench for adder17_arbiter: models the shared adder and the requesters, with a
// scoreboard queue filled at each grant and drained by a monitor on every result.
module tb_adder17_arbiter;

    logic           clk;
    logic           rst;
    logic [3:0]     req_valid;
    logic [67:0]    req_a;
    logic [67:0]    req_b;
    logic [3:0]     req_ready;
    logic [0:16]    add_a;
    logic [0:16]    add_b;
    logic [0:17]    add_sum;
    logic           res_valid;
    logic [1:0]     res_id;
    logic [0:17]    res_data;
    logic           res_ready;

    adder17_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    // The shared adder itself
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [17:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    int          gcyc[$];
    logic [17:0] pend_e[4];
    int          rep[4];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        rv_seen = 1'b0;
    int          rv_cyc = 0;
    logic [3:0]  g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input int i, input logic [16:0] a, input logic [16:0] b,
                        input logic [17:0] e, input int r);
        req_a[17*i +: 17] = a;
        req_b[17*i +: 17] = b;
        pend_e[i]         = e;
        rep[i]            = r;
        req_valid[i]      = 1'b1;
    endtask

    // One clock: record grants seen before the edge, then retire or re-arm requesters.
    task automatic step(output logic [3:0] gv);
        logic [3:0] acc;
        exp_t       e;
        acc = '0;
        @(negedge clk);
        gv = req_ready;
        chk("grant_onehot", ($countones(req_ready) <= 1), 1);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc[i] = 1'b1;
                e.id   = i;
                e.data = pend_e[i];
                e.acc  = cyc;
                sb.push_back(e);
                glog.push_back(i);
                gcyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (rep[i] > 0) rep[i] = rep[i] - 1;
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic run_idle();
        logic [3:0] gt;
        int         n;
        n = 0;
        while (((req_valid != 4'b0) || (sb.size() != 0) || res_valid) && (n < 100)) begin
            step(gt);
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_idle_timeout: got %0d cycles, expected < 100", n);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pend_e[i] = '0;
            rep[i]    = 0;
        end

        fork
            begin : main_seq
                int exp_f[8];
                repeat (2) @(posedge clk);
                #1;
                req_valid = 4'hF;
                #1;
                chk("rst_req_ready", req_ready, 0);
                chk("rst_add_a", add_a, 0);
                chk("rst_add_b", add_b, 0);
                chk("rst_res_valid", res_valid, 0);
                chk("rst_res_id", res_id, 0);
                chk("rst_res_data", res_data, 0);
                req_valid = '0;
                rst       = 1'b0;

                // Single request
                load(0, 17'h00005, 17'h00003, 18'h00008, 0);
                step(g);
                chk("t1_grant", g, 4'b0001);
                #1;
                chk("t1_add_a", add_a, 17'h00005);
                chk("t1_add_b", add_b, 17'h00003);
                run_idle();

                // Carry boundary
                load(2, 17'h1FFFF, 17'h1FFFF, 18'h3FFFE, 0);
                step(g);
                chk("t2_grant", g, 4'b0100);
                run_idle();
                load(2, 17'h10000, 17'h10000, 18'h20000, 0);
                run_idle();

                // Fairness, pointer left at 3 by the previous grants
                glog.delete();
                gcyc.delete();
                load(0, 17'h00001, 17'h00002, 18'h00003, 1);
                load(1, 17'h00100, 17'h00200, 18'h00300, 1);
                load(2, 17'h01000, 17'h00FFF, 18'h01FFF, 1);
                load(3, 17'h0FFFF, 17'h00001, 18'h10000, 1);
                run_idle();
                exp_f = '{3, 0, 1, 2, 3, 0, 1, 2};
                chk("t3_count", glog.size(), 8);
                for (int k = 0; k < 8; k++) chk($sformatf("t3_order%0d", k), glog[k], exp_f[k]);
                for (int k = 1; k < 8; k++) chk($sformatf("t3_spacing%0d", k), gcyc[k] - gcyc[k-1], 2);

                // Backpressure
                res_ready = 1'b0;
                load(0, 17'h0AAAA, 17'h05555, 18'h0FFFF, 0);
                load(1, 17'h00007, 17'h00009, 18'h00010, 0);
                step(g);
                chk("t4_grant0", g, 4'b0001);
                step(g);
                chk("t4_add_cycle", g, 4'b0000);
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("t4_hold_valid", res_valid, 1);
                    chk("t4_hold_id", res_id, 0);
                    chk("t4_hold_data", res_data, 18'h0FFFF);
                    chk("t4_hold_ready", req_ready, 0);
                    step(g);
                end
                res_ready = 1'b1;
                step(g);
                chk("t4_grant1", g, 4'b0010);
                run_idle();

                // Wrap and skip: bring pointer to 3 first
                load(2, 17'h00001, 17'h00001, 18'h00002, 0);
                run_idle();
                glog.delete();
                load(1, 17'h00400, 17'h00400, 18'h00800, 0);
                load(3, 17'h12345, 17'h0ABCD, 18'h1CF12, 0);
                run_idle();
                chk("t5_count", glog.size(), 2);
                chk("t5_first", glog[0], 3);
                chk("t5_second", glog[1], 1);

                // Reset during ADD
                load(1, 17'h00010, 17'h00020, 18'h00030, 0);
                step(g);
                chk("t6_grant", g, 4'b0010);
                rst = 1'b1;
                #1;
                chk("t6_req_ready", req_ready, 0);
                chk("t6_res_valid", res_valid, 0);
                chk("t6_add_a", add_a, 0);
                chk("t6_add_b", add_b, 0);
                chk("t6_res_id", res_id, 0);
                chk("t6_res_data", res_data, 0);
                sb.delete();
                rv_seen = 1'b0;
                @(posedge clk);
                #1;
                chk("t6_res_valid_held", res_valid, 0);
                rst = 1'b0;
                glog.delete();
                load(0, 17'h00001, 17'h1FFFF, 18'h20000, 0);
                load(3, 17'h00002, 17'h00003, 18'h00005, 0);
                run_idle();
                chk("t6_count", glog.size(), 2);
                chk("t6_first", glog[0], 0);
                chk("t6_second", glog[1], 3);
            end
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (res_valid && !rv_seen) begin
                        rv_seen = 1'b1;
                        rv_cyc  = cyc;
                    end
                    if (res_valid && res_ready) begin
                        if (sb.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_result: got id %0d data 0x%0h, expected none",
                                     res_id, res_data);
                        end else begin
                            e = sb.pop_front();
                            chk("res_id", res_id, e.id);
                            chk("res_data", res_data, e.data);
                            chk("res_latency", rv_cyc - e.acc, 2);
                        end
                        rv_seen = 1'b0;
                    end
                end
            end
        join_any
        disable fork;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder17_arbiter.md
Name: adder17_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 17+17→18-bit unsigned adder among NUM_REQ requesters in the ANN datapath (e.g. neuron partial-sum units).
- Accepts one operand pair at a time over valid/ready and drives the shared adder's operand inputs from registers.
- Captures the adder's 18-bit sum and returns it on a single result channel, tagged with the requester ID.
- One transaction in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has an operand pair pending.
- req_a  input  17*NUM_REQ  operand A of requester i in slice [17*i +: 17].
- req_b  input  17*NUM_REQ  operand B of requester i in slice [17*i +: 17].
- req_ready  output  NUM_REQ  one-hot grant; bit i high means requester i's pair is accepted this cycle.
- add_a  output  [0:16]  registered operand A to the shared adder (bit 0 = MSB).
- add_b  output  [0:16]  registered operand B to the shared adder (bit 0 = MSB).
- add_sum  input  [0:17]  combinational sum returned by the shared adder (bit 0 = MSB).
- res_valid  output  1  result available.
- res_id  output  ID_W  index of the requester that owns the result.
- res_data  output  [0:17]  registered 18-bit unsigned sum.
- res_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: req_ready=0, add_a=0, add_b=0, res_valid=0, res_id=0, res_data=0.
  - Internal: FSM=IDLE, round-robin pointer=0.
  - Reset mid-operation discards any in-flight pair or result; no ready or valid is asserted while rst=1.
- FSM states: IDLE, ADD, RESP.
- Grant:
  - req_ready is combinational: zero unless (state==IDLE) or (state==RESP and res_ready==1).
  - When allowed, at most one bit is set: the first requester with req_valid high, searching from the pointer upward and wrapping at NUM_REQ-1 → 0.
  - Acceptance is req_valid[i] & req_ready[i].
- On acceptance:
  - req_a/req_b slice i is registered into add_a/add_b.
  - Grant index is registered as the pending ID.
  - Pointer ← (i+1) mod NUM_REQ; FSM → ADD.
  - A requester that is not granted keeps its data stable; requesters must not drop valid before ready.
- ADD (exactly 1 cycle): res_data ← add_sum, res_id ← pending ID, FSM → RESP.
- RESP:
  - res_valid=1; res_data and res_id are held stable until res_ready.
  - res_ready=1 with a new acceptance in the same cycle: FSM → ADD (back-to-back).
  - res_ready=1 with no new acceptance: FSM → IDLE.
  - res_ready=0: remain in RESP.
- Latency: acceptance at cycle T → res_valid at T+2 (with res_ready held high). Peak throughput is 1 result per 2 cycles.
- Arithmetic:
  - Unsigned; carry out lands in add_sum bit 0 (MSB).
  - Max case 0x1FFFF+0x1FFFF = 0x3FFFE; no truncation or saturation.
- add_a/add_b hold their last values outside ADD; only the value sampled in ADD matters.
- Pointer advances only on acceptance; idle cycles do not rotate priority.

Test Plan:
- Reset then single request: req_valid=0001, A=0x00005, B=0x00003 → req_ready=0001 same cycle; two cycles later res_valid=1, res_id=0, res_data=0x00008; res_ready=1 → IDLE.
- Carry boundary: requester 2 sends A=0x1FFFF, B=0x1FFFF → res_id=2, res_data=0x3FFFE; then A=0x10000, B=0x10000 → 0x20000.
- Fairness: all four requesters valid continuously, res_ready=1 → grant order 0,1,2,3,0,…; one result every 2 cycles; no requester granted twice before the others.
- Backpressure: res_ready=0 for 5 cycles in RESP → res_valid, res_data and res_id are stable, req_ready=0; raising res_ready grants the next pending requester in the same cycle.
- Wrap and skip: pointer at 3, only requesters 1 and 3 valid → 3 granted first, then 1.
- Reset mid-operation: assert rst during ADD → res_valid stays 0, all outputs 0 immediately; after release, requester 0 has highest priority.
